// File: rtl/formula_sweep_pkg.sv
// Shared types and constants for the exhaustive formula sweep stage.
package formula_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int N_IN_DEFAULT = 7;

  // One extra bit so a sweep where every assignment satisfies cannot wrap.
  function automatic int cnt_width(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/formula_sweep_slot.sv
// Single-entry valid/ready output register holding one satisfying assignment.
module sweep_slot #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Free when empty or being drained this cycle; lets a load overlap a consume.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {W{1'b0}};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/formula_sweep.sv
// Walks every input assignment of a combinational formula in ascending order
// and streams out the satisfying ones, with a count and end-of-sweep pulse.
module formula_sweep
  import formula_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [N_IN-1:0]            vec_o,
  input  logic                       f_i,
  output logic                       sat_valid,
  input  logic                       sat_ready,
  output logic [N_IN-1:0]            sat_vec,
  output logic [cnt_width(N_IN)-1:0] sat_count,
  output logic                       busy,
  output logic                       done
);

  localparam int              CW      = cnt_width(N_IN);
  localparam logic [N_IN-1:0] IDX_MAX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  state_t          r_state;
  logic [N_IN-1:0] r_idx;
  logic [CW-1:0]   r_count;
  logic            r_busy;
  logic            r_done;

  logic w_free;
  logic w_in_sweep;
  logic w_load;
  logic w_advance;

  // A satisfying assignment is only consumed when the slot can take it;
  // otherwise idx holds and f_i is re-evaluated on the same vector.
  assign w_in_sweep = (r_state == ST_SWEEP);
  assign w_load     = w_in_sweep && f_i && w_free;
  assign w_advance  = w_in_sweep && (!f_i || w_free);

  sweep_slot #(.W(N_IN)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (r_idx),
    .i_ready (sat_ready),
    .o_valid (sat_valid),
    .o_data  (sat_vec),
    .o_free  (w_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= {N_IN{1'b0}};
      r_count <= {CW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SWEEP;
            r_idx   <= {N_IN{1'b0}};
            r_count <= {CW{1'b0}};
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (w_load) begin
            r_count <= r_count + CNT_ONE;
          end
          // The last assignment parks vec_o at all-ones instead of wrapping.
          if (w_advance) begin
            if (r_idx == IDX_MAX) begin
              r_state <= ST_DRAIN;
            end else begin
              r_idx <= r_idx + IDX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (w_free) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_idx   <= {N_IN{1'b0}};
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= {N_IN{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_o     = r_idx;
  assign sat_count = r_count;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_formula_sweep.sv
// Directed bench for formula_sweep (N_IN=7) with a behavioural formula driven from vec_o.
module tb_formula_sweep;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] vec_o;
  logic       f_i;
  logic       sat_valid;
  logic       sat_ready;
  logic [6:0] sat_vec;
  logic [7:0] sat_count;
  logic       busy;
  logic       done;

  int mode;
  int n_cmp;
  int n_err;
  int hs_q[$];

  formula_sweep #(.N_IN(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_o     (vec_o),
    .f_i       (f_i),
    .sat_valid (sat_valid),
    .sat_ready (sat_ready),
    .sat_vec   (sat_vec),
    .sat_count (sat_count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Formula under test: 0 const0, 1 AND-all, 2 LSB, 3 const1
  always_comb begin
    case (mode)
      0: f_i = 1'b0;
      1: f_i = &vec_o;
      2: f_i = vec_o[0];
      3: f_i = 1'b1;
      default: f_i = 1'b0;
    endcase
  end

  // Runs one sweep and records observations; cycle k is the interval after edge k.
  task automatic do_sweep(input int rmode, input int restart_idx,
                          output int done_cyc, output int n_done,
                          output int busy_first, output int busy_last,
                          output int n_busy, output int n_unstable);
    logic       pstall;
    logic [6:0] pvec;
    hs_q.delete();
    done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1;
    n_busy = 0; n_unstable = 0; pstall = 1'b0; pvec = 7'd0;
    @(negedge clk);
    start = 1'b1;
    sat_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc < 700; cyc++) begin
      @(negedge clk);
      start = (restart_idx >= 0 && busy && vec_o == restart_idx[6:0]) ? 1'b1 : 1'b0;
      sat_ready = (rmode == 0) ? 1'b1 : ((cyc % 2) == 1);
      #1;
      if (pstall && (!sat_valid || sat_vec !== pvec)) n_unstable++;
      if (sat_valid && sat_ready) hs_q.push_back(int'(sat_vec));
      if (busy) begin
        n_busy++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      pstall = sat_valid && !sat_ready;
      pvec = sat_vec;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    sat_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (vec_o !== 7'd0) begin n_err++; $display("FAIL reset_vec actual=%0d required=0", vec_o); end
    n_cmp++; if (sat_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid actual=%b required=0", sat_valid); end
    n_cmp++; if (sat_vec !== 7'd0) begin n_err++; $display("FAIL reset_satvec actual=%0d required=0", sat_vec); end
    n_cmp++; if (sat_count !== 8'd0) begin n_err++; $display("FAIL reset_count actual=%0d required=0", sat_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy actual=%b required=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done actual=%b required=0", done); end
    rst = 1'b0;
  endtask

  task automatic test_f_zero();
    int dc, nd, bf, bl, nb, nu;
    mode = 0;
    do_sweep(0, -1, dc, nd, bf, bl, nb, nu);
    n_cmp++; if (hs_q.size() != 0) begin n_err++; $display("FAIL zero_handshakes actual=%0d required=0", hs_q.size()); end
    n_cmp++; if (dc != 130) begin n_err++; $display("FAIL zero_done_cycle actual=%0d required=130", dc); end
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL zero_done_pulses actual=%0d required=1", nd); end
    n_cmp++; if (sat_count !== 8'd0) begin n_err++; $display("FAIL zero_count actual=%0d required=0", sat_count); end
    n_cmp++; if (bf != 1 || bl != 129 || nb != 129) begin
      n_err++; $display("FAIL zero_busy_window actual=%0d..%0d (%0d) required=1..129 (129)", bf, bl, nb);
    end
  endtask

  task automatic test_f_and();
    int dc, nd, bf, bl, nb, nu;
    mode = 1;
    do_sweep(0, -1, dc, nd, bf, bl, nb, nu);
    n_cmp++; if (hs_q.size() != 1) begin n_err++; $display("FAIL and_handshakes actual=%0d required=1", hs_q.size()); end
    n_cmp++; if (hs_q.size() < 1 || hs_q[0] != 127) begin n_err++; $display("FAIL and_vector actual=%0d required=127", (hs_q.size() > 0) ? hs_q[0] : -1); end
    n_cmp++; if (sat_count !== 8'd1) begin n_err++; $display("FAIL and_count actual=%0d required=1", sat_count); end
    n_cmp++; if (dc != 130) begin n_err++; $display("FAIL and_done_cycle actual=%0d required=130", dc); end
  endtask

  task automatic test_f_lsb();
    int dc, nd, bf, bl, nb, nu, bad;
    mode = 2;
    do_sweep(0, -1, dc, nd, bf, bl, nb, nu);
    bad = 0;
    foreach (hs_q[i]) if (hs_q[i] != 2 * i + 1) bad++;
    n_cmp++; if (hs_q.size() != 64) begin n_err++; $display("FAIL lsb_handshakes actual=%0d required=64", hs_q.size()); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL lsb_order actual=%0d_out_of_order required=0", bad); end
    n_cmp++; if (sat_count !== 8'd64) begin n_err++; $display("FAIL lsb_count actual=%0d required=64", sat_count); end
    n_cmp++; if (dc != 130) begin n_err++; $display("FAIL lsb_done_cycle actual=%0d required=130", dc); end
  endtask

  task automatic test_back_to_back();
    int dc, nd, bf, bl, nb, nu, bad;
    mode = 3;
    do_sweep(1, -1, dc, nd, bf, bl, nb, nu);
    bad = 0;
    foreach (hs_q[i]) if (hs_q[i] != i) bad++;
    n_cmp++; if (hs_q.size() != 128) begin n_err++; $display("FAIL b2b_handshakes actual=%0d required=128", hs_q.size()); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_order actual=%0d_out_of_order required=0", bad); end
    n_cmp++; if (nu != 0) begin n_err++; $display("FAIL b2b_stall_stable actual=%0d_changes required=0", nu); end
    n_cmp++; if (sat_count !== 8'h80) begin n_err++; $display("FAIL b2b_count actual=%0d required=128", sat_count); end
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL b2b_done_pulses actual=%0d required=1", nd); end
  endtask

  task automatic test_mid_reset();
    int dc, nd, bf, bl, nb, nu, found;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vec_o == 7'd40) begin found = 1; break; end
    end
    n_cmp++; if (found != 1) begin n_err++; $display("FAIL midrst_reach40 actual=%0d required=1", found); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (vec_o !== 7'd0 || sat_valid !== 1'b0 || sat_vec !== 7'd0 ||
                 sat_count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrst_outputs actual=vec%0d v%b sv%0d c%0d b%b d%b required=all_zero",
                        vec_o, sat_valid, sat_vec, sat_count, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    do_sweep(0, -1, dc, nd, bf, bl, nb, nu);
    n_cmp++; if (sat_count !== 8'd64 || hs_q.size() != 64) begin
      n_err++; $display("FAIL midrst_rerun actual=count%0d hs%0d required=64/64", sat_count, hs_q.size());
    end
    n_cmp++; if (dc != 130) begin n_err++; $display("FAIL midrst_done_cycle actual=%0d required=130", dc); end
  endtask

  task automatic test_restart_ignored();
    int dc, nd, bf, bl, nb, nu, bad;
    mode = 2;
    do_sweep(0, 10, dc, nd, bf, bl, nb, nu);
    bad = 0;
    foreach (hs_q[i]) if (hs_q[i] != 2 * i + 1) bad++;
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL restart_done_pulses actual=%0d required=1", nd); end
    n_cmp++; if (hs_q.size() != 64 || bad != 0) begin
      n_err++; $display("FAIL restart_order actual=hs%0d bad%0d required=64/0", hs_q.size(), bad);
    end
    n_cmp++; if (dc != 130) begin n_err++; $display("FAIL restart_done_cycle actual=%0d required=130", dc); end
    n_cmp++; if (sat_count !== 8'd64) begin n_err++; $display("FAIL restart_count actual=%0d required=64", sat_count); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sat_ready = 1'b1;
    mode = 0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_f_zero();
    test_f_and();
    test_f_lsb();
    test_back_to_back();
    test_mid_reset();
    test_restart_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/formula_sweep.md
Name: formula_sweep

Overview:
- Exhaustive stimulus/evaluation stage placed directly upstream of a combinational benchmark formula (N_IN single-bit inputs, one output).
- Enumerates all 2^N_IN input assignments in ascending order and drives each onto the formula.
- Samples the formula output in the same cycle and streams every satisfying assignment out over a valid/ready interface.
- Reports the satisfying-assignment count and a done pulse. Used for truth-table checking of synthesized candidates against benchmark specs.

Parameters:
- N_IN, 7, number of formula inputs; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored unless in IDLE
- vec_o  out  N_IN  assignment driven to the formula; bit k drives formula input ik
- f_i  in  1  formula output; combinational function of vec_o, sampled in the same cycle
- sat_valid  out  1  sat_vec holds an unconsumed satisfying assignment
- sat_ready  in  1  consumer accepts sat_vec when sat_valid && sat_ready
- sat_vec  out  N_IN  satisfying assignment
- sat_count  out  N_IN+1  number of satisfying assignments captured in the current or last sweep
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  one-cycle pulse at the end of a sweep

Behaviour:
- Reset values: vec_o=0, sat_valid=0, sat_vec=0, sat_count=0, busy=0, done=0, state=IDLE. Reset mid-sweep aborts the sweep immediately; no done pulse is produced.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - vec_o holds 0.
  - On start: go to SWEEP, clear sat_count, set idx=0.
- SWEEP:
  - vec_o=idx every cycle.
  - Output slot is "free" when sat_valid==0 or the slot is being consumed this cycle (sat_valid && sat_ready).
  - If f_i==1 and the slot is free: load sat_vec<=idx, set sat_valid<=1, increment sat_count, advance idx.
  - If f_i==1 and the slot is not free: stall. idx and vec_o hold, nothing is counted, and f_i is re-sampled next cycle.
  - If f_i==0: advance idx.
  - Advancing from idx=2^N_IN-1: do not wrap; go to DRAIN with vec_o held at all-ones.
- DRAIN:
  - If the slot is free this cycle, go to DONE. Otherwise wait.
  - DRAIN lasts at least one cycle.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - sat_count holds its value until the next start.
- sat_valid clears on a handshake unless reloaded in the same cycle. Simultaneous consume and load is legal and keeps sat_valid=1 with the new vector.
- sat_vec and sat_valid must stay stable while sat_valid && !sat_ready.
- Timing with no stalls: start sampled at edge 0 → SWEEP covers cycles 1..2^N_IN → DRAIN at 2^N_IN+1 → done at 2^N_IN+2. For N_IN=7, done is at cycle 130.
- sat_count is N_IN+1 bits so that a full count of 2^N_IN cannot overflow.
- start while busy or during DONE is ignored; it is not queued.

Decomposition:
- Shared package (formula_sweep_pkg):
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - default N_IN constant;
  - count-width function (N_IN+1).
- One sub-module, sweep_slot:
  - the single-entry valid/ready output register;
  - parameterised by width;
  - exposes a "free" signal to the FSM.

Test Plan:
- f_i = 0 constant, sat_ready=1, start at cycle 0 → sat_valid never asserts; done pulses at cycle 130; sat_count=0; busy high on cycles 1..129.
- f_i = &vec_o, sat_ready=1 → exactly one handshake with sat_vec=127; sat_count=1; done at cycle 130.
- f_i = vec_o[0], sat_ready=1 → 64 handshakes with vectors 1,3,...,127 in order; sat_count=64; done at cycle 130.
- f_i = 1 constant, sat_ready toggling 1,0,1,0 → all 128 vectors 0..127 delivered in order with none lost or duplicated; sat_valid/sat_vec stable while stalled; sat_count=128 (0x80).
- Mid-sweep rst at idx=40 → next cycle all outputs at reset values; a new start runs a full sweep with correct count.
- start pulsed again at idx=10 → ignored; exactly one done pulse; sweep order unaffected.
